packet_tx_framer: RTL and testbench
===================================

# packet_tx_framer

- Sits directly downstream of the send-packet counter: each counter `PULSE` drives `START`, and the framer emits one framed packet.
- Byte stream out on a valid/ready handshake: header byte, 8-bit sequence number, `PAYLOAD_BYTES` payload bytes, 8-bit checksum.
- One start request is queued while a packet is in flight; further requests are dropped and flagged.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 4, number of payload bytes per packet (1..16)
- `HEADER`, 8'hA5, constant first byte of every packet

Ports:
- `CLK`  in  1  single clock, rising edge
- `RESET_N`  in  1  asynchronous, active-low reset
- `START`  in  1  single-cycle request to send a packet (from counter `PULSE`)
- `PAYLOAD`  in  8*PAYLOAD_BYTES  payload word, sampled at packet launch; byte [8*PAYLOAD_BYTES-1 -: 8] sent first
- `TX_DATA`  out  8  current output byte
- `TX_VALID`  out  1  `TX_DATA` is valid
- `TX_READY`  in  1  sink accepts the byte this cycle
- `TX_LAST`  out  1  high with the checksum byte
- `BUSY`  out  1  packet in flight or request pending
- `DROP`  out  1  one-cycle pulse: a start request was discarded
- `SEQ`  out  8  sequence number of the next or current packet

## Operation
- States: IDLE, HDR, SEQN, PAY, CSUM.
- Transfer occurs on any cycle with `TX_VALID && TX_READY`.
- IDLE:
  - On `START` (or pending flag set), capture `PAYLOAD` into a shift register, clear the checksum accumulator, go to HDR.
  - Pending flag is cleared at launch.
- HDR: `TX_DATA=HEADER`; on transfer go to SEQN.
- SEQN:
  - `TX_DATA=SEQ`; checksum accumulates `SEQ`.
  - On transfer go to PAY with byte index 0.
- PAY:
  - `TX_DATA` = top byte of the shift register; checksum accumulates each byte.
  - On transfer, shift left 8 and increment the index.
  - After byte `PAYLOAD_BYTES-1` go to CSUM.
- CSUM:
  - `TX_DATA` = checksum; `TX_LAST=1`.
  - On transfer, `SEQ` increments (255 wraps to 0).
  - Next state is HDR if pending (relaunch, capture `PAYLOAD` at that edge), else IDLE.
- Checksum: 8-bit modulo-256 sum of `SEQ` and all payload bytes. The header is excluded; carries are discarded.
- Pending flag:
  - Set by `START` in any state other than IDLE, including the cycle of the CSUM transfer.
  - `START` in IDLE launches directly and does not set pending.
- Drop:
  - `START` while pending is already set leaves pending set and pulses `DROP` the next cycle.
  - Drops are not counted.
- `BUSY` = (state != IDLE) || pending.
- Reset (async, any time):
  - State goes to IDLE; pending, shift register, checksum and `SEQ` clear.
  - A packet in flight is abandoned with no `TX_LAST`.

## Timing
- Reset values: `TX_DATA=0`, `TX_VALID=0`, `TX_LAST=0`, `BUSY=0`, `DROP=0`, `SEQ=0`.
- All outputs are registered or decoded only from registered state; there is no combinational path from `TX_READY` to any output.
- Launch latency: `START` high in IDLE at edge t gives `TX_VALID=1` with `HEADER` from cycle t+1.
- Throughput: one byte per cycle while `TX_READY=1`. A packet occupies `PAYLOAD_BYTES+3` cycles.
- Back-to-back: with pending set, the header of the next packet appears the cycle after the CSUM transfer, with no idle gap.
- Handshake rules:
  - Once `TX_VALID` rises it stays high until the transfer.
  - `TX_DATA` and `TX_LAST` are held stable while `TX_VALID && !TX_READY`.
  - `TX_VALID` never depends on `TX_READY`.
- `PAYLOAD` changes after the launch edge do not affect the packet in flight.
- `SEQ` updates at the edge of the CSUM transfer; during a packet it shows the current packet's number.

## Test plan
- **Single packet, no backpressure.** Stimulus: `PAYLOAD=32'h01020304`, `TX_READY=1`, `START` at t, `SEQ=0`. Required response:
  - Bytes A5,00,01,02,03,04,0A on cycles t+1..t+7.
  - `TX_LAST` only with 0A.
  - `SEQ=1` afterwards; `BUSY` low at t+8.
- **Backpressure.** Stimulus: same packet with `TX_READY` toggling 1,0,0,1,... Required response:
  - Byte sequence identical to the single-packet case.
  - `TX_DATA` stable during every stall; `TX_VALID` never drops mid-packet.
- **Queued start.** Stimulus: second `START` during PAY with `PAYLOAD` changed to 32'hFFFFFFFF at the CSUM transfer. Required response:
  - Second packet's header follows the first CSUM immediately.
  - Second packet is A5,01,FF,FF,FF,FF,FD.
  - No `DROP`.
- **Drop.** Stimulus: three `START` pulses during one packet. Required response:
  - Exactly one `DROP` pulse, one cycle after the third `START`.
  - Exactly two packets sent in total.
- **Sequence wrap.** Stimulus: 257 packets with payload 0. Required response:
  - Packet 256 has `SEQ`=FF and checksum FF.
  - Packet 257 has `SEQ`=00 and checksum 00.
- **Reset mid-packet.** Stimulus: `RESET_N` low asynchronously during PAY, then a new `START` after release. Required response:
  - All outputs go to reset values immediately.
  - The new packet starts with A5,00.

Source files
------------

// File: rtl/packet_tx_framer.sv
// packet_tx_framer: frames each START request into HEADER, SEQ, payload bytes and checksum on a valid/ready byte stream
// Ports: CLK/RESET_N clock and async active-low reset; START launch request; PAYLOAD word captured at launch;
//        TX_DATA/TX_VALID/TX_READY/TX_LAST byte stream; BUSY in flight or pending; DROP discarded request; SEQ packet number
module packet_tx_framer #(
   parameter int unsigned PAYLOAD_BYTES = 4,
   parameter logic [7:0]  HEADER        = 8'hA5
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic                       START,
   input  logic [8*PAYLOAD_BYTES-1:0] PAYLOAD,
   output logic [7:0]                 TX_DATA,
   output logic                       TX_VALID,
   input  logic                       TX_READY,
   output logic                       TX_LAST,
   output logic                       BUSY,
   output logic                       DROP,
   output logic [7:0]                 SEQ
);
   localparam int         W        = 8 * PAYLOAD_BYTES;
   localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);
   typedef enum logic [2:0] {IDLE, HDR, SEQN, PAY, CSUM} state_t;
   state_t         state_q, state_d;
   logic           pend_q, pend_d, drop_q, drop_d;
   logic [W-1:0]   shreg_q, shreg_d;
   logic [7:0]     csum_q, csum_d, seq_q, seq_d;
   logic [3:0]     idx_q, idx_d;
   logic [7:0]     top_byte;
   logic           xfer, launch;
   assign top_byte = shreg_q[W-1 -: 8];
   assign xfer     = TX_VALID && TX_READY;
   // a queued request relaunches straight out of the CSUM transfer, giving back-to-back packets
   assign launch   = (state_q == IDLE && (START || pend_q)) || (state_q == CSUM && xfer && pend_q);
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      csum_d  = csum_q;
      seq_d   = seq_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: state_d = IDLE;
         HDR:  if (xfer) state_d = SEQN;
         SEQN: if (xfer) begin
            state_d = PAY;
            csum_d  = csum_q + seq_q;
            idx_d   = 4'd0;
         end
         PAY:  if (xfer) begin
            csum_d  = csum_q + top_byte;
            shreg_d = shreg_q << 8;
            idx_d   = idx_q + 4'd1;
            state_d = (idx_q == LAST_IDX) ? CSUM : PAY;
         end
         CSUM: if (xfer) begin
            seq_d   = seq_q + 8'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d = HDR;
         shreg_d = PAYLOAD;
         csum_d  = 8'd0;
         idx_d   = 4'd0;
      end
      // a START coinciding with a relaunch re-queues rather than being dropped
      pend_d = (START && state_q != IDLE) ? 1'b1 : launch ? 1'b0 : pend_q;
      drop_d = START && pend_q && !launch;
   end
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         drop_q  <= 1'b0;
         shreg_q <= '0;
         csum_q  <= 8'd0;
         seq_q   <= 8'd0;
         idx_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         shreg_q <= shreg_d;
         csum_q  <= csum_d;
         seq_q   <= seq_d;
         idx_q   <= idx_d;
      end
   end
   assign TX_VALID = state_q != IDLE;
   assign TX_LAST  = state_q == CSUM;
   assign TX_DATA  = (state_q == HDR)  ? HEADER :
                     (state_q == SEQN) ? seq_q :
                     (state_q == PAY)  ? top_byte :
                     (state_q == CSUM) ? csum_q : 8'h00;
   assign BUSY     = (state_q != IDLE) || pend_q;
   assign DROP     = drop_q;
   assign SEQ      = seq_q;
endmodule

// File: tb/tb_packet_tx_framer.sv
// tb_packet_tx_framer: directed self-checking bench for packet_tx_framer
module tb_packet_tx_framer;
   logic        CLK = 1'b0, RESET_N = 1'b0, START = 1'b0, TX_READY = 1'b0;
   logic [31:0] PAYLOAD = '0;
   logic [7:0]  TX_DATA, SEQ;
   logic        TX_VALID, TX_LAST, BUSY, DROP;
   int          errors = 0, checks = 0, cyc_cnt = 0;
   logic [7:0]  q_data[$];
   logic        q_last[$];
   int          q_cyc[$];
   int          drop_cyc[$];
   logic        stalled = 1'b0, stall_last = 1'b0;
   logic [7:0]  stall_data = '0;

   packet_tx_framer #(.PAYLOAD_BYTES(4), .HEADER(8'hA5)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .START(START), .PAYLOAD(PAYLOAD),
      .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_LAST(TX_LAST),
      .BUSY(BUSY), .DROP(DROP), .SEQ(SEQ)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge CLK) begin
      if (stalled && RESET_N) begin
         chk("stall_valid", TX_VALID, 1);
         chk("stall_data", TX_DATA, stall_data);
         chk("stall_last", TX_LAST, stall_last);
      end
      stalled    = TX_VALID && !TX_READY && RESET_N;
      stall_data = TX_DATA;
      stall_last = TX_LAST;
      if (TX_VALID && TX_READY) begin
         q_data.push_back(TX_DATA);
         q_last.push_back(TX_LAST);
         q_cyc.push_back(cyc_cnt);
      end
      if (DROP) drop_cyc.push_back(cyc_cnt);
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic launch(output int t);
      START = 1'b1;
      cyc();
      START = 1'b0;
      t = cyc_cnt;
   endtask

   task automatic clear_q();
      q_data.delete();
      q_last.delete();
      q_cyc.delete();
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      cyc(2);
      RESET_N = 1'b1;
      cyc();
      clear_q();
      drop_cyc.delete();
   endtask

   task automatic wait_bytes(input int n, input string tag);
      int k = 0;
      while (q_data.size() < n && k < 200) begin
         cyc();
         k++;
      end
      chk({tag, "_timeout"}, q_data.size() >= n, 1);
   endtask

   task automatic check_pkt(input string tag, input logic [55:0] exp, input int t0);
      int c;
      if (q_data.size() < 7) begin
         chk({tag, "_count"}, q_data.size(), 7);
         return;
      end
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("%s_b%0d", tag, i), q_data.pop_front(), exp[55-8*i -: 8]);
         chk($sformatf("%s_last%0d", tag, i), q_last.pop_front(), i == 6);
         c = q_cyc.pop_front();
         if (t0 >= 0) chk($sformatf("%s_cyc%0d", tag, i), c, t0 + i);
      end
   endtask

   initial begin
      int t;
      int n_last;
      #1;
      chk("rst_data", TX_DATA, 0);
      chk("rst_valid", TX_VALID, 0);
      chk("rst_last", TX_LAST, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_drop", DROP, 0);
      chk("rst_seq", SEQ, 0);
      cyc(2);
      RESET_N = 1'b1;
      cyc();
      PAYLOAD  = 32'h01020304;
      TX_READY = 1'b1;
      launch(t);
      wait_bytes(7, "single");
      chk("single_busy_after", BUSY, 0);
      chk("single_valid_after", TX_VALID, 0);
      chk("single_seq_after", SEQ, 1);
      check_pkt("single", 56'hA5_00_01_02_03_04_0A, t);
      START    = 1'b1;
      TX_READY = 1'b1;
      for (int k = 0; k < 60 && q_data.size() < 7; k++) begin
         cyc();
         START    = 1'b0;
         TX_READY = (k % 3 == 2);
      end
      check_pkt("bp", 56'hA5_01_01_02_03_04_0B, -1);
      TX_READY = 1'b1;
      cyc(2);
      chk("bp_seq_after", SEQ, 2);
      do_reset();
      PAYLOAD = 32'h01020304;
      launch(t);
      cyc(2);
      START = 1'b1;
      cyc();
      START = 1'b0;
      chk("queue_busy", BUSY, 1);
      cyc(3);
      PAYLOAD = 32'hFFFFFFFF;
      wait_bytes(14, "queue");
      check_pkt("queue1", 56'hA5_00_01_02_03_04_0A, t);
      check_pkt("queue2", 56'hA5_01_FF_FF_FF_FF_FD, t + 7);
      chk("queue_drops", drop_cyc.size(), 0);
      chk("queue_busy_after", BUSY, 0);
      PAYLOAD = 32'h01020304;
      launch(t);
      PAYLOAD = 32'hDEADBEEF;
      cyc();
      START = 1'b1;
      cyc();
      START = 1'b0;
      cyc();
      START = 1'b1;
      cyc();
      START = 1'b0;
      wait_bytes(14, "drop");
      check_pkt("drop1", 56'hA5_02_01_02_03_04_0C, t);
      check_pkt("drop2", 56'hA5_03_DE_AD_BE_EF_3B, t + 7);
      chk("drop_count", drop_cyc.size(), 1);
      if (drop_cyc.size() > 0) chk("drop_cycle", drop_cyc[0], t + 4);
      cyc(10);
      chk("drop_no_third", q_data.size(), 0);
      chk("drop_busy_after", BUSY, 0);
      chk("drop_seq_after", SEQ, 4);
      do_reset();
      PAYLOAD = 32'h0;
      for (int k = 0; k < 257; k++) begin
         launch(t);
         wait_bytes(7, "wrap");
         if (q_data.size() < 7) break;
         if (k >= 255) check_pkt($sformatf("wrap%0d", k + 1), {8'hA5, 8'(k), 32'h0, 8'(k)}, t);
         else clear_q();
      end
      chk("wrap_seq_after", SEQ, 1);
      clear_q();
      PAYLOAD = 32'h01020304;
      launch(t);
      cyc(3);
      #2;
      RESET_N = 1'b0;
      #1;
      chk("arst_data", TX_DATA, 0);
      chk("arst_valid", TX_VALID, 0);
      chk("arst_last", TX_LAST, 0);
      chk("arst_busy", BUSY, 0);
      chk("arst_drop", DROP, 0);
      chk("arst_seq", SEQ, 0);
      n_last = 0;
      foreach (q_last[i]) n_last += int'(q_last[i]);
      chk("arst_no_last", n_last, 0);
      chk("arst_partial", q_data.size(), 3);
      #3;
      RESET_N = 1'b1;
      clear_q();
      cyc();
      launch(t);
      wait_bytes(7, "arst_new");
      check_pkt("arst_new", 56'hA5_00_01_02_03_04_0A, t);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
